pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-sequencing stage that sits directly downstream of the branch-target lookup table.
- Drives the 5-bit LUT index and consumes the 10-bit Target it returns. Produces the 10-bit PC that addresses instruction memory.
- Sequences each program run: Start, then run, then halt/Done, for the test-bench handshake.

Parameters:
- PC_W, 10, PC and Target width (instruction memory depth 2^PC_W).
- IDX_W, 5, LUT index width.
- START_PC, 0, PC value loaded when a run begins.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset (sampled on the rising edge of Clk).
- Start  in  1  begin a run; honoured in IDLE and HALT only.
- Stall  in  1  freeze PC, state and counters this cycle.
- BranchEn  in  1  current instruction is a taken branch.
- BranchAbs  in  1  1 = absolute jump to Target; 0 = PC-relative by Target.
- LutIdx  in  IDX_W  branch-target pointer from decode.
- Target  in  PC_W  target returned by the LUT (combinational, same cycle).
- Halt  in  1  current instruction is the program-terminating instruction.
- LutAddr  out  IDX_W  index to the LUT; combinational copy of LutIdx.
- PC  out  PC_W  current instruction address.
- Running  out  1  high in RUN state.
- Done  out  1  high in HALT state.
- Wrapped  out  1  sticky flag: sequential increment wrapped 2^PC_W-1 to 0.
- InstCount  out  CNT_W  retired instructions in the current run.
- BrCount  out  CNT_W  taken branches in the current run (see Optional Feature).

Behaviour:
- Reset (Reset_n=0 at an edge), from any state including mid-run:
  - state=IDLE, PC=START_PC, Done=0, Running=0, Wrapped=0, InstCount=0, BrCount=0.
- States: IDLE, RUN, HALT. Encodings are defined in the shared package.
- IDLE:
  - PC held at START_PC.
  - Start=1 → RUN next cycle, with PC=START_PC and counters cleared.
- RUN, priority per edge is Stall > Halt > BranchEn > increment:
  - Stall=1: everything held; nothing counted; Start ignored.
  - Halt=1: next state HALT; PC held at the halt address; InstCount+1. A simultaneous BranchEn is ignored.
  - BranchEn=1, BranchAbs=1: PC ← Target.
  - BranchEn=1, BranchAbs=0: PC ← PC + Target, with Target taken as signed two's complement PC_W bits, modulo 2^PC_W. No Wrapped update on this path.
  - Any branch: InstCount+1, BrCount+1.
  - Otherwise: PC ← PC+1. If PC was 2^PC_W-1, PC becomes 0 and Wrapped←1. InstCount+1.
  - Start while in RUN is ignored.
- HALT:
  - Done=1; PC held.
  - Start=1 → RUN with PC=START_PC, counters cleared, Wrapped cleared, Done drops the next cycle.
- Counters saturate at all-ones (no wrap).
- Latency:
  - LutAddr is combinational from LutIdx.
  - The PC update appears one cycle after the branch is presented.
  - Done rises the cycle after Halt is sampled in RUN.
- All outputs except LutAddr are registered or decoded from registered state.

Optional Feature:
- Macro: PC_FETCH_BRCOUNT_EN.
- Defined: BrCount is implemented as specified.
- Undefined: the BrCount register is not built and the port is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, HALT);
  - PC_W, IDX_W, CNT_W defaults;
  - the typedef for the PC address.
- One sub-module: sat_counter, a CNT_W saturating counter with clear and enable. It is instantiated for InstCount and BrCount.

Test Plan:
- Reset_n=0 mid-run at PC=0x025 → next edge: PC=0, state IDLE, Done=0, InstCount=0.
- Start pulse, 5 plain cycles → PC=5, InstCount=5, Running=1.
- At PC=0x010: BranchEn=1, BranchAbs=1, LutIdx=5'h03, Target=10'h053 → LutAddr=3 same cycle; PC=0x053 next cycle; BrCount=1.
- At PC=0x040: relative branch with Target=10'h3FC (-4) → PC=0x03C. At PC=0x3FF with no branch → PC=0x000, Wrapped=1.
- Stall=1 for 3 cycles with BranchEn=1 → PC and counters unchanged. Halt and BranchEn together → HALT, PC unchanged, Done=1, BrCount unchanged.
- From HALT, Start=1 → PC=START_PC, InstCount=0, Done=0. Repeat with PC_FETCH_BRCOUNT_EN undefined → BrCount stays 0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default widths for the PC / fetch-sequencing stage.
package pc_fetch_ctrl_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int IDX_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef logic [PC_W_DEF-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: run handshake, branch/LUT inputs and PC/status outputs.
interface pc_fetch_ctrl_if
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             Start;
  logic             Stall;
  logic             BranchEn;
  logic             BranchAbs;
  logic [IDX_W-1:0] LutIdx;
  logic [PC_W-1:0]  Target;
  logic             Halt;
  logic [IDX_W-1:0] LutAddr;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic             Wrapped;
  logic [CNT_W-1:0] InstCount;
  logic [CNT_W-1:0] BrCount;

  modport master (
    output Start, Stall, BranchEn, BranchAbs, LutIdx, Target, Halt,
    input  LutAddr, PC, Running, Done, Wrapped, InstCount, BrCount
  );

  modport slave (
    input  Start, Stall, BranchEn, BranchAbs, LutIdx, Target, Halt,
    output LutAddr, PC, Running, Done, Wrapped, InstCount, BrCount
  );

endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run sequencer (IDLE -> RUN -> HALT) fed by the branch LUT.
// Optional macro PC_FETCH_BRCOUNT_EN builds the taken-branch counter; otherwise BrCount is 0.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              IDX_W    = IDX_W_DEF,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              CNT_W    = CNT_W_DEF
) (
  input logic            Clk,
  input logic            Reset_n,
  pc_fetch_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             wrapped_q, wrapped_d;
  logic             cnt_clr;
  logic             inst_inc;
  logic             br_inc;
  logic [CNT_W-1:0] inst_cnt;

  // Stall freezes everything; in RUN the order is Halt > branch > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
    cnt_clr   = 1'b0;
    inst_inc  = 1'b0;
    br_inc    = 1'b0;
    if (!bus.Stall) begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (bus.Start) begin
            state_d   = ST_RUN;
            pc_d      = START_PC;
            wrapped_d = 1'b0;
            cnt_clr   = 1'b1;
          end
        end
        ST_RUN: begin
          inst_inc = 1'b1;
          if (bus.Halt) begin
            state_d = ST_HALT;
          end else if (bus.BranchEn) begin
            br_inc = 1'b1;
            pc_d   = bus.BranchAbs ? bus.Target : pc_q + bus.Target;
          end else begin
            pc_d = pc_q + PC_W'(1);
            if (pc_q == '1) begin
              wrapped_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clr_i   (cnt_clr),
    .en_i    (inst_inc),
    .count_o (inst_cnt)
  );

`ifdef PC_FETCH_BRCOUNT_EN
  logic [CNT_W-1:0] br_cnt;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clr_i   (cnt_clr),
    .en_i    (br_inc),
    .count_o (br_cnt)
  );

  assign bus.BrCount = br_cnt;
`else
  logic unused_br_inc;
  assign unused_br_inc = br_inc;
  assign bus.BrCount   = '0;
`endif

  assign bus.LutAddr   = IDX_W'(bus.LutIdx);
  assign bus.PC        = pc_q;
  assign bus.Running   = (state_q == ST_RUN);
  assign bus.Done      = (state_q == ST_HALT);
  assign bus.Wrapped   = wrapped_q;
  assign bus.InstCount = inst_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed table, corner sequences and random run vs. a model.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam int PC_MOD  = 1 << PC_W_DEF;
  localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

  typedef struct {
    logic       start, stall, ben, babs, halt;
    logic [4:0] idx;
    logic [9:0] tgt;
    logic [9:0] ePc;
    logic       eRun, eDone, eWrap;
    int         eInst, eBr;
  } vec_t;

  logic Clk;
  logic Reset_n;
  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  logic       satRst, satClr, satEn;
  logic [2:0] satCount;

  sat_counter #(.W(3)) uSat (
    .clk     (Clk),
    .rst_n   (satRst),
    .clr_i   (satClr),
    .en_i    (satEn),
    .count_o (satCount)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int mState, mPc, mWrapped, mInst, mBr;

  vec_t tbl[13];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish before 2000000");
    $fatal(1, "[TB] timeout");
  end

  function automatic int brExp(int n);
`ifdef PC_FETCH_BRCOUNT_EN
    return n;
`else
    return n & 0;
`endif
  endfunction

  function automatic int satInc(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic vec_t mk(logic start, logic stall, logic ben, logic babs, logic halt,
                              logic [4:0] idx, logic [9:0] tgt, logic [9:0] ePc,
                              logic eRun, logic eDone, logic eWrap, int eInst, int eBr);
    vec_t v;
    v.start = start; v.stall = stall; v.ben = ben; v.babs = babs; v.halt = halt;
    v.idx = idx; v.tgt = tgt; v.ePc = ePc;
    v.eRun = eRun; v.eDone = eDone; v.eWrap = eWrap; v.eInst = eInst; v.eBr = eBr;
    return v;
  endfunction

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    int off;
    if (!Reset_n) begin
      mState = 0; mPc = 0; mWrapped = 0; mInst = 0; mBr = 0;
    end else if (bus.Stall) begin
    end else if (mState != 1) begin
      if (bus.Start) begin
        mState = 1; mPc = 0; mWrapped = 0; mInst = 0; mBr = 0;
      end
    end else if (bus.Halt) begin
      mState = 2;
      mInst  = satInc(mInst);
    end else if (bus.BranchEn) begin
      if (bus.BranchAbs) begin
        mPc = int'(bus.Target);
      end else begin
        off = int'(bus.Target);
        if (off >= PC_MOD / 2) off = off - PC_MOD;
        mPc = (mPc + off + PC_MOD) % PC_MOD;
      end
      mInst = satInc(mInst);
      mBr   = satInc(mBr);
    end else begin
      mPc = mPc + 1;
      if (mPc == PC_MOD) begin
        mPc = 0;
        mWrapped = 1;
      end
      mInst = satInc(mInst);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stall, input logic ben,
                               input logic babs, input logic halt,
                               input logic [4:0] idx, input logic [9:0] tgt);
    bus.Start = start; bus.Stall = stall; bus.BranchEn = ben; bus.BranchAbs = babs;
    bus.Halt = halt; bus.LutIdx = idx; bus.Target = tgt;
    #1;
    check("LutAddr", 32'(bus.LutAddr), 32'(idx));
    @(posedge Clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(string tag);
    check({tag, ".PC"},        32'(bus.PC),        32'(mPc));
    check({tag, ".Running"},   32'(bus.Running),   32'(mState == 1));
    check({tag, ".Done"},      32'(bus.Done),      32'(mState == 2));
    check({tag, ".Wrapped"},   32'(bus.Wrapped),   32'(mWrapped));
    check({tag, ".InstCount"}, 32'(bus.InstCount), 32'(mInst));
    check({tag, ".BrCount"},   32'(bus.BrCount),   32'(brExp(mBr)));
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
  endtask

  initial begin
    int snapPc, snapInst, snapBr;
    Reset_n = 1'b0;
    satRst = 1'b0; satClr = 1'b0; satEn = 1'b0;
    bus.Start = 1'b0; bus.Stall = 1'b0; bus.BranchEn = 1'b0; bus.BranchAbs = 1'b0;
    bus.Halt = 1'b0; bus.LutIdx = '0; bus.Target = '0;
    mState = 0; mPc = 0; mWrapped = 0; mInst = 0; mBr = 0;

    //           st stl ben abs hlt idx    tgt       ePc      run dn wr inst br
    tbl[0]  = mk(1, 0,  0,  0,  0,  5'h00, 10'h000, 10'h000, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0,  0,  0,  0,  5'h01, 10'h000, 10'h001, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0,  0,  0,  0,  5'h02, 10'h000, 10'h002, 1, 0, 0, 2, 0);
    tbl[3]  = mk(1, 0,  0,  0,  0,  5'h00, 10'h000, 10'h003, 1, 0, 0, 3, 0);
    tbl[4]  = mk(0, 0,  0,  0,  0,  5'h00, 10'h000, 10'h004, 1, 0, 0, 4, 0);
    tbl[5]  = mk(0, 0,  0,  0,  0,  5'h00, 10'h000, 10'h005, 1, 0, 0, 5, 0);
    tbl[6]  = mk(0, 0,  1,  1,  0,  5'h0A, 10'h010, 10'h010, 1, 0, 0, 6, 1);
    tbl[7]  = mk(0, 0,  1,  1,  0,  5'h03, 10'h053, 10'h053, 1, 0, 0, 7, 2);
    tbl[8]  = mk(0, 0,  1,  0,  0,  5'h1F, 10'h3FC, 10'h04F, 1, 0, 0, 8, 3);
    tbl[9]  = mk(0, 1,  1,  1,  0,  5'h11, 10'h200, 10'h04F, 1, 0, 0, 8, 3);
    tbl[10] = mk(0, 0,  1,  1,  1,  5'h04, 10'h123, 10'h04F, 0, 1, 0, 9, 3);
    tbl[11] = mk(0, 0,  0,  0,  0,  5'h00, 10'h000, 10'h04F, 0, 1, 0, 9, 3);
    tbl[12] = mk(1, 0,  0,  0,  0,  5'h00, 10'h000, 10'h000, 1, 0, 0, 0, 0);

    $display("[TB] reset phase");
    idleCycle();
    idleCycle();
    check("reset.PC", 32'(bus.PC), 32'h0);
    check("reset.Running", 32'(bus.Running), 32'h0);
    check("reset.Done", 32'(bus.Done), 32'h0);
    check("reset.InstCount", 32'(bus.InstCount), 32'h0);
    checkOutput("reset");
    Reset_n = 1'b1;
    idleCycle();
    check("idle.PC", 32'(bus.PC), 32'h0);
    check("idle.Running", 32'(bus.Running), 32'h0);

    $display("[TB] directed table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].start, tbl[i].stall, tbl[i].ben, tbl[i].babs, tbl[i].halt,
                    tbl[i].idx, tbl[i].tgt);
      check($sformatf("vec%0d.PC", i), 32'(bus.PC), 32'(tbl[i].ePc));
      check($sformatf("vec%0d.Running", i), 32'(bus.Running), 32'(tbl[i].eRun));
      check($sformatf("vec%0d.Done", i), 32'(bus.Done), 32'(tbl[i].eDone));
      check($sformatf("vec%0d.Wrapped", i), 32'(bus.Wrapped), 32'(tbl[i].eWrap));
      check($sformatf("vec%0d.InstCount", i), 32'(bus.InstCount), 32'(tbl[i].eInst));
      check($sformatf("vec%0d.BrCount", i), 32'(bus.BrCount), 32'(brExp(tbl[i].eBr)));
      checkOutput($sformatf("vec%0d", i));
    end

    $display("[TB] wrap sequence");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h07, 10'h3FE);
    idleCycle();
    check("wrap.PC3FF", 32'(bus.PC), 32'h3FF);
    check("wrap.before", 32'(bus.Wrapped), 32'h0);
    idleCycle();
    check("wrap.PC0", 32'(bus.PC), 32'h000);
    check("wrap.flag", 32'(bus.Wrapped), 32'h1);
    idleCycle();
    check("wrap.sticky", 32'(bus.Wrapped), 32'h1);
    checkOutput("wrap");

    $display("[TB] relative branch sequence");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h02, 10'h040);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h02, 10'h3FC);
    check("rel.PC", 32'(bus.PC), 32'h03C);
    check("rel.WrappedKept", 32'(bus.Wrapped), 32'h1);
    checkOutput("rel");

    $display("[TB] stall and halt sequence");
    snapPc = mPc; snapInst = mInst; snapBr = mBr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'h09, 10'h155);
      check("stall.PC", 32'(bus.PC), 32'(snapPc));
      check("stall.InstCount", 32'(bus.InstCount), 32'(snapInst));
      check("stall.BrCount", 32'(bus.BrCount), 32'(brExp(snapBr)));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'h09, 10'h155);
    check("halt.PC", 32'(bus.PC), 32'(snapPc));
    check("halt.Done", 32'(bus.Done), 32'h1);
    check("halt.InstCount", 32'(bus.InstCount), 32'(snapInst + 1));
    check("halt.BrCount", 32'(bus.BrCount), 32'(brExp(snapBr)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 10'h000);
    check("restart.PC", 32'(bus.PC), 32'h000);
    check("restart.InstCount", 32'(bus.InstCount), 32'h0);
    check("restart.Done", 32'(bus.Done), 32'h0);
    check("restart.Wrapped", 32'(bus.Wrapped), 32'h0);
    check("restart.BrCount", 32'(bus.BrCount), 32'h0);

    $display("[TB] mid-run reset sequence");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h05, 10'h025);
    check("midrst.PCbefore", 32'(bus.PC), 32'h025);
    Reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 10'h000);
    Reset_n = 1'b1;
    check("midrst.PC", 32'(bus.PC), 32'h000);
    check("midrst.Running", 32'(bus.Running), 32'h0);
    check("midrst.Done", 32'(bus.Done), 32'h0);
    check("midrst.InstCount", 32'(bus.InstCount), 32'h0);
    checkOutput("midrst");

    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      logic st, stl, ben, babs, hlt;
      logic [9:0] tgt;
      Reset_n = ($urandom_range(0, 199) != 0);
      stl  = ($urandom_range(0, 7) == 0);
      st   = !stl && ($urandom_range(0, 7) == 0);
      hlt  = ($urandom_range(0, 15) == 0);
      ben  = ($urandom_range(0, 3) == 0);
      babs = 1'($urandom_range(0, 1));
      tgt  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 1023))
                                          : 10'($urandom_range(1018, 1029));
      applyStimulus(st, stl, ben, babs, hlt, 5'($urandom_range(0, 31)), tgt);
      checkOutput($sformatf("rnd%0d", n));
    end
    Reset_n = 1'b1;

    $display("[TB] saturating counter sequence");
    idleCycle();
    check("sat.reset", 32'(satCount), 32'h0);
    satRst = 1'b1;
    satEn  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      idleCycle();
      check($sformatf("sat.step%0d", i), 32'(satCount), 32'((i > 7) ? 7 : i));
    end
    satClr = 1'b1;
    idleCycle();
    check("sat.clear", 32'(satCount), 32'h0);
    satClr = 1'b0;
    satEn  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
